// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory bootloader: FSM encodings,
// error codes and small helpers used by the loader and its word packer.
package instr_mem_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // States that belong to an open frame (busy, timeout armed).
    function automatic logic in_frame(input logic [2:0] st);
        return (st == ST_LEN_LO) || (st == ST_LEN_HI) ||
               (st == ST_DATA)   || (st == ST_CSUM);
    endfunction

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words and emits a one-cycle
// word_valid_o pulse, with the word, on the cycle after the fourth byte.
module word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] acc_q,   acc_d;
    logic        valid_q, valid_d;
    logic [31:0] word_q,  word_d;

    // Byte placement: byte k lands in bits [8k+7:8k]; the fourth byte closes the word.
    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        valid_d = 1'b0;
        word_d  = word_q;
        if (clear_i) begin
            idx_d = 2'd0;
            acc_d = 24'd0;
        end else if (byte_valid_i) begin
            case (idx_q)
                2'd0: acc_d[7:0]   = byte_i;
                2'd1: acc_d[15:8]  = byte_i;
                2'd2: acc_d[23:16] = byte_i;
                2'd3: begin
                    word_d  = {byte_i, acc_q};
                    valid_d = 1'b1;
                end
                default: acc_d = acc_q;
            endcase
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= 2'd0;
            acc_q   <= 24'd0;
            valid_q <= 1'b0;
            word_q  <= 32'd0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign last_byte_o  = (idx_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream bootloader: parses SYNC/LEN/DATA/CSUM frames, writes words into
// instruction memory and holds the core in reset until a good image is loaded.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 256,
    parameter int          TIMEOUT_CYC = 1000,
    parameter bit          BOOT_HOLD   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
    localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);

    logic [2:0]    state_q,    state_d;
    logic [15:0]   len_q,      len_d;
    logic [15:0]   wcnt_q,     wcnt_d;
    logic [7:0]    csum_q,     csum_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic [31:0]   addr_q,     addr_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;
    logic [1:0]    code_q,     code_d;
    logic          core_rst_q, core_rst_d;
    logic          busy_q,     busy_d;

    logic          accept_s;
    logic          pk_clear_s;
    logic          pk_byte_valid_s;
    logic          pk_last_s;
    logic          pk_word_valid_s;
    logic [31:0]   pk_word_s;
    logic [15:0]   len_full_s;
    logic [15:0]   wcnt_inc_s;
    logic [TW-1:0] tmo_inc_s;

    assign ready_o    = 1'b1;
    assign accept_s   = valid_i & ready_o;
    assign len_full_s = {data_i, len_q[7:0]};
    assign wcnt_inc_s = wcnt_q + 16'd1;
    assign tmo_inc_s  = tmo_q + {{(TW-1){1'b0}}, 1'b1};

    word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (pk_clear_s),
        .byte_valid_i (pk_byte_valid_s),
        .byte_i       (data_i),
        .last_byte_o  (pk_last_s),
        .word_valid_o (pk_word_valid_s),
        .word_o       (pk_word_s)
    );

    // Frame FSM, checksum, word/address counters and inter-byte timeout.
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        wcnt_d          = wcnt_q;
        csum_d          = csum_q;
        tmo_d           = tmo_q;
        done_d          = done_q;
        err_d           = err_q;
        code_d          = code_q;
        core_rst_d      = core_rst_q;
        pk_clear_s      = 1'b0;
        pk_byte_valid_s = 1'b0;

        if (pk_word_valid_s) begin
            addr_d = addr_q + 32'd4;
        end else begin
            addr_d = addr_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept_s && (data_i == SYNC_BYTE)) begin
                    state_d    = ST_LEN_LO;
                    len_d      = 16'd0;
                    wcnt_d     = 16'd0;
                    csum_d     = 8'd0;
                    tmo_d      = '0;
                    addr_d     = BASE_ADDR;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    code_d     = ERR_NONE;
                    core_rst_d = 1'b1;
                    pk_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = data_i;
                    state_d    = ST_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d = len_full_s;
                    if ({1'b0, len_full_s} > MAX_LEN) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else if (len_full_s == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    pk_byte_valid_s = 1'b1;
                    csum_d          = csum_next(csum_q, data_i);
                    if (pk_last_s) begin
                        wcnt_d = wcnt_inc_s;
                        if (wcnt_inc_s == len_q) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (data_i == csum_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte always beats an expiring timeout.
        if (in_frame(state_q)) begin
            if (accept_s) begin
                tmo_d = '0;
            end else if (tmo_inc_s == TMO_LIMIT) begin
                tmo_d   = '0;
                state_d = ST_ERROR;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_inc_s;
            end
        end else begin
            tmo_d = tmo_d;
        end

        busy_d = in_frame(state_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            len_q      <= 16'd0;
            wcnt_q     <= 16'd0;
            csum_q     <= 8'd0;
            tmo_q      <= '0;
            addr_q     <= BASE_ADDR;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            core_rst_q <= BOOT_HOLD;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_we_o    = pk_word_valid_s;
    assign mem_wdata_o = pk_word_s;
    assign mem_addr_o  = addr_q;
    assign core_rst_o  = core_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a frame-level reference model checked
// every cycle, plus literal expectations on captured memory writes and flags.
module tb_instr_mem_loader;

    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          MAXW    = 256;
    localparam int          TIMEOUT = 1000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int checks = 0;
    int errors = 0;

    instr_mem_loader #(
        .SYNC_BYTE   (SYNC),
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TIMEOUT),
        .BOOT_HOLD   (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .core_rst_o  (core_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the frame by byte position, not by FSM state.
    logic        m_act, m_done, m_err, m_core, m_we;
    logic [1:0]  m_code;
    logic [15:0] m_len;
    logic [7:0]  m_cs;
    logic [31:0] m_word, m_wdata;
    int          m_pos, m_idle, m_wr;

    always @(posedge clk_i or posedge rst_i) begin : model
        logic        act, dn, er, cr, we;
        logic [1:0]  cd;
        logic [15:0] len;
        logic [7:0]  cs;
        logic [31:0] wrd, wd;
        int          pos, idle, wr, d;
        if (rst_i) begin
            m_act <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_core <= 1'b1; m_we <= 1'b0;
            m_code <= 2'b00; m_len <= 16'd0; m_cs <= 8'd0; m_word <= 32'd0; m_wdata <= 32'd0;
            m_pos <= 0; m_idle <= 0; m_wr <= 0;
        end else begin
            act = m_act; dn = m_done; er = m_err; cr = m_core; cd = m_code;
            len = m_len; cs = m_cs; wrd = m_word; wd = m_wdata;
            pos = m_pos; idle = m_idle; wr = m_wr;
            if (m_we) wr = wr + 1;
            we = 1'b0;
            if (!act) begin
                if (valid_i && data_i == SYNC) begin
                    act = 1'b1; pos = 0; idle = 0; cs = 8'd0; wr = 0;
                    dn = 1'b0; er = 1'b0; cd = 2'b00; cr = 1'b1;
                end
            end else if (valid_i) begin
                idle = 0;
                if (pos == 0) begin
                    len[7:0] = data_i;
                end else if (pos == 1) begin
                    len[15:8] = data_i;
                    if (int'(len) > MAXW) begin act = 1'b0; er = 1'b1; cd = 2'b01; end
                end else if (pos < 2 + 4 * int'(len)) begin
                    d = pos - 2;
                    wrd[8*(d%4) +: 8] = data_i;
                    cs = cs ^ data_i;
                    if (d % 4 == 3) begin we = 1'b1; wd = wrd; end
                end else begin
                    act = 1'b0;
                    if (data_i == cs) begin dn = 1'b1; cr = 1'b0; end
                    else begin er = 1'b1; cd = 2'b10; end
                end
                pos = pos + 1;
            end else begin
                idle = idle + 1;
                if (idle == TIMEOUT) begin act = 1'b0; er = 1'b1; cd = 2'b11; end
            end
            m_act <= act; m_done <= dn; m_err <= er; m_core <= cr; m_we <= we;
            m_code <= cd; m_len <= len; m_cs <= cs; m_word <= wrd; m_wdata <= wd;
            m_pos <= pos; m_idle <= idle; m_wr <= wr;
        end
    end

    always @(negedge clk_i) begin : compare
        chk("ready",    {31'd0, ready_o},    32'd1);
        chk("we",       {31'd0, mem_we_o},   {31'd0, m_we});
        chk("addr",     mem_addr_o,          BASE + 32'(4 * m_wr));
        chk("wdata",    mem_wdata_o,         m_wdata);
        chk("core_rst", {31'd0, core_rst_o}, {31'd0, m_core});
        chk("busy",     {31'd0, busy_o},     {31'd0, m_act});
        chk("done",     {31'd0, done_o},     {31'd0, m_done});
        chk("err",      {31'd0, err_o},      {31'd0, m_err});
        chk("err_code", {30'd0, err_code_o}, {30'd0, m_code});
    end

    logic [31:0] cap [256];
    int          n_wr = 0;

    always @(negedge clk_i) begin : capture
        if (mem_we_o) begin
            cap[mem_addr_o[9:2]] = mem_wdata_o;
            n_wr = n_wr + 1;
        end
    end

    logic [7:0] fr_ok    [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h24};
    logic [7:0] fr_bad   [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] fr_len   [3]  = '{8'hA5, 8'h01, 8'h01};
    logic [7:0] fr_tmo   [4]  = '{8'hA5, 8'h01, 8'h00, 8'hAA};
    logic [7:0] fr_empty [4]  = '{8'hA5, 8'h00, 8'h00, 8'h00};
    logic [7:0] fr_sync  [8]  = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5};
    logic [7:0] fr_part  [5]  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02};
    logic [7:0] fr_fresh [8]  = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};

    task automatic send(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    int base;

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        idle(3);
        chk("lit_rst_core", {31'd0, core_rst_o}, 32'd1);
        chk("lit_rst_addr", mem_addr_o, 32'h0);
        rst_i = 1'b0;

        base = n_wr;
        foreach (fr_ok[i]) send(fr_ok[i]);
        idle(2);
        chk("lit_ok_done",   {31'd0, done_o},     32'd1);
        chk("lit_ok_code",   {30'd0, err_code_o}, 32'd0);
        chk("lit_ok_core",   {31'd0, core_rst_o}, 32'd0);
        chk("lit_ok_nwr",    32'(n_wr - base),    32'd2);
        chk("lit_ok_w0",     cap[0],              32'h0000_0013);
        chk("lit_ok_w1",     cap[1],              32'h0000_0037);

        base = n_wr;
        foreach (fr_bad[i]) send(fr_bad[i]);
        idle(2);
        chk("lit_bad_err",   {31'd0, err_o},      32'd1);
        chk("lit_bad_code",  {30'd0, err_code_o}, 32'd2);
        chk("lit_bad_core",  {31'd0, core_rst_o}, 32'd1);
        chk("lit_bad_nwr",   32'(n_wr - base),    32'd2);

        base = n_wr;
        foreach (fr_len[i]) send(fr_len[i]);
        idle(2);
        chk("lit_len_code",  {30'd0, err_code_o}, 32'd1);
        chk("lit_len_busy",  {31'd0, busy_o},     32'd0);
        chk("lit_len_nwr",   32'(n_wr - base),    32'd0);

        foreach (fr_tmo[i]) send(fr_tmo[i]);
        idle(TIMEOUT - 1);
        chk("lit_tmo_pre",   {31'd0, err_o},      32'd0);
        idle(1);
        chk("lit_tmo_err",   {31'd0, err_o},      32'd1);
        chk("lit_tmo_code",  {30'd0, err_code_o}, 32'd3);
        send(8'hA5);
        chk("lit_tmo_clr",   {31'd0, err_o},      32'd0);
        send(8'h00); send(8'h00); send(8'h00);

        send(8'h00); send(8'hFF);
        chk("lit_garb_busy", {31'd0, busy_o},     32'd0);
        base = n_wr;
        foreach (fr_empty[i]) send(fr_empty[i]);
        idle(2);
        chk("lit_empty_done", {31'd0, done_o},    32'd1);
        chk("lit_empty_nwr", 32'(n_wr - base),    32'd0);

        base = n_wr;
        foreach (fr_sync[i]) send(fr_sync[i]);
        idle(2);
        chk("lit_sync_done", {31'd0, done_o},     32'd1);
        chk("lit_sync_w0",   cap[0],              32'h3322_11A5);
        chk("lit_sync_nwr",  32'(n_wr - base),    32'd1);

        foreach (fr_part[i]) send(fr_part[i]);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("lit_mid_busy",  {31'd0, busy_o},     32'd0);
        chk("lit_mid_core",  {31'd0, core_rst_o}, 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        base = n_wr;
        foreach (fr_fresh[i]) send(fr_fresh[i]);
        idle(2);
        chk("lit_fresh_done", {31'd0, done_o},    32'd1);
        chk("lit_fresh_core", {31'd0, core_rst_o}, 32'd0);
        chk("lit_fresh_w0",  cap[0],              32'hDEAD_BEEF);
        chk("lit_fresh_nwr", 32'(n_wr - base),    32'd1);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
